relu_seq_ctrl: RTL and testbench
================================

# relu_seq_ctrl

Sequencer that streams a vector of 16-bit activations from a source buffer through the `relu_module` datapath and writes the results to a destination buffer. It sits between the NPU buffer memories and `relu_module`, owning that block's `Data_Reg`, `EN_ReLU` and `BYPASS_ReLU` inputs. Each job is started by a one-cycle `START`. The controller also counts the negative inputs of the current job.

## Interface
- `ADDR_W`, default 8: buffer address width; maximum job length is 2^ADDR_W−1.
- `CLKEXT` in 1: system clock; all state changes on its rising edge.
- `RST_GLO` in 1: reset, synchronous, active-high.
- `START` in 1: one-cycle job request; sampled only in IDLE.
- `ABORT` in 1: synchronous job cancel.
- `LEN` in ADDR_W: element count; latched on START.
- `MODE` in 2: 00 = clear (zero out), 01 = ReLU, 10 = bypass, 11 = ReLU; latched on START.
- `SRC_BASE`, `DST_BASE` in ADDR_W each: start addresses; latched on START.
- `SRC_RD_EN` out 1, `SRC_ADDR` out ADDR_W: source read port. Read latency is 1 cycle.
- `SRC_DATA` in 16: source read data, valid the cycle after `SRC_RD_EN`.
- `Data_Reg` out 16, `EN_ReLU` out 1, `BYPASS_ReLU` out 1: drive `relu_module`.
- `ReLU_OUT` in 16: registered `relu_module` output.
- `DST_WR_EN` out 1, `DST_ADDR` out ADDR_W, `DST_DATA` out 16: destination write port.
- `BUSY` out 1: high from the cycle after an accepted START until the cycle DONE pulses, inclusive.
- `DONE` out 1: one-cycle pulse when the job completes normally.
- `NEG_CNT` out ADDR_W: number of inputs with bit 15 set in the current or last job.

## Operation
- **States:** IDLE, RUN, DRAIN, FINISH.
- **IDLE, START=1, LEN≠0:** latch LEN, MODE, bases; clear issue index, write index and NEG_CNT; go to RUN.
- **IDLE, START=1, LEN=0:** go to FINISH. No reads, no writes.
- **RUN:** each cycle, `SRC_RD_EN`=1 and `SRC_ADDR`=(SRC_BASE+i) mod 2^ADDR_W; i increments. After issuing i=LEN−1, go to DRAIN.
- **DRAIN:** no reads; wait until the write of element LEN−1 completes, then go to FINISH.
- **FINISH:** `DONE`=1 for one cycle, then IDLE.
- **Capture:** `Data_Reg` is registered from `SRC_DATA` in the cycle after each read. It holds its value otherwise.
- **Counting:** NEG_CNT increments when a captured word has bit 15 = 1, independent of MODE. Width ADDR_W, so no overflow is possible.
- **Datapath controls:** during BUSY, `EN_ReLU`=(MODE[0]==1), `BYPASS_ReLU`=(MODE==10). Both are 0 in IDLE.
- **Write port:** `DST_DATA` = `ReLU_OUT` (combinational pass-through); `DST_ADDR`=(DST_BASE+w) mod 2^ADDR_W, w = write index.
- **Address wrap:** base + index wraps modulo 2^ADDR_W with no error flag.
- **START while BUSY:** ignored; latched parameters are unchanged.
- **ABORT in any non-IDLE state:** go to IDLE next edge.
  - All pending reads and writes are suppressed from the following cycle on.
  - No DONE pulse.
  - NEG_CNT keeps its partial value.
- **ABORT and START in the same IDLE cycle:** ABORT wins; START is ignored.
- **RST_GLO:** overrides everything, including mid-job; no DONE.

## Timing
- **Pipeline:** element i is read in cycle t. `SRC_DATA` is valid in t+1, `Data_Reg` in t+2, `ReLU_OUT` in t+3. `DST_WR_EN`=1 in t+3 with DST_ADDR=DST_BASE+i.
- **Throughput:** 1 element per cycle; LEN elements produce LEN consecutive write cycles.
- **Job timing:** START accepted at edge e0. The first read occurs in the cycle after e0. The last write occurs LEN+2 cycles after the first read. DONE is high in the cycle after the last write. BUSY falls together with DONE's cycle end.
- **LEN=0:** DONE pulses in the cycle after the START edge; BUSY is high for that single cycle.
- **Back-to-back jobs:** a new START is accepted in the cycle after DONE, at the earliest.
- **Reset values:**
  - state IDLE
  - `SRC_RD_EN`=`DST_WR_EN`=`DONE`=`BUSY`=0
  - `EN_ReLU`=`BYPASS_ReLU`=0
  - `SRC_ADDR`=`DST_ADDR`=0
  - `Data_Reg`=0
  - `NEG_CNT`=0

## Test plan
- **ReLU job:** MODE=01, LEN=4, SRC=[0x0005,0x8001,0x7FFF,0xFFFF] at base 0x10, DST_BASE=0x20. Expect writes 0x20..0x23 = [0x0005,0x0000,0x7FFF,0x0000] on 4 consecutive cycles, NEG_CNT=2, one DONE pulse.
- **Bypass and clear:** same data with MODE=10 → DST = SRC unchanged, NEG_CNT=2. With MODE=00 → DST = all 0x0000.
- **Address wrap:** ADDR_W=8, SRC_BASE=0xFE, DST_BASE=0xFF, LEN=3. Expect reads at 0xFE,0xFF,0x00 and writes at 0xFF,0x00,0x01.
- **LEN=0:** DONE pulses 1 cycle after START; SRC_RD_EN and DST_WR_EN never asserted.
- **Abort and busy-START:** ABORT in the 3rd RUN cycle of a LEN=8 job → no writes after the next edge, no DONE, IDLE. A second START during BUSY is ignored.
- **Reset mid-job:** RST_GLO in DRAIN → all outputs at reset values next cycle. A new job then runs correctly.

Source files
------------

// File: rtl/relu_seq_ctrl.sv
// rtl/relu_seq_ctrl.sv - streams a source buffer through relu_module into a destination buffer
// Read issue, capture and write-back form a three-stage valid pipeline behind a four-state job FSM.
module relu_seq_ctrl #(
   parameter int ADDR_W = 8
) (
   input  logic              CLKEXT,
   input  logic              RST_GLO,
   input  logic              START,
   input  logic              ABORT,
   input  logic [ADDR_W-1:0] LEN,
   input  logic [1:0]        MODE,
   input  logic [ADDR_W-1:0] SRC_BASE,
   input  logic [ADDR_W-1:0] DST_BASE,
   output logic              SRC_RD_EN,
   output logic [ADDR_W-1:0] SRC_ADDR,
   input  logic [15:0]       SRC_DATA,
   output logic [15:0]       Data_Reg,
   output logic              EN_ReLU,
   output logic              BYPASS_ReLU,
   input  logic [15:0]       ReLU_OUT,
   output logic              DST_WR_EN,
   output logic [ADDR_W-1:0] DST_ADDR,
   output logic [15:0]       DST_DATA,
   output logic              BUSY,
   output logic              DONE,
   output logic [ADDR_W-1:0] NEG_CNT
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_FINISH
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] len_last;
   logic [1:0]        mode_q;
   logic [ADDR_W-1:0] src_base_q;
   logic [ADDR_W-1:0] dst_base_q;
   logic [ADDR_W-1:0] rd_idx;
   logic [ADDR_W-1:0] wr_idx;
   logic              vld_cap;
   logic              vld_relu;
   logic              vld_wr;
   logic [15:0]       data_q;
   logic [ADDR_W-1:0] neg_cnt;
   logic              accept;

   assign len_last = len_q - ADDR_W'(1);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            if (START && !ABORT) begin
               if (LEN == '0) begin
                  state_nxt = S_FINISH;
               end else begin
                  state_nxt = S_RUN;
                  accept    = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (rd_idx == len_last) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (vld_wr && (wr_idx == len_last)) state_nxt = S_FINISH;
         end
         S_FINISH: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
      if (ABORT) state_nxt = S_IDLE;
   end

   always_ff @(posedge CLKEXT) begin
      if (RST_GLO) begin
         state      <= S_IDLE;
         len_q      <= '0;
         mode_q     <= 2'b00;
         src_base_q <= '0;
         dst_base_q <= '0;
         rd_idx     <= '0;
         wr_idx     <= '0;
         vld_cap    <= 1'b0;
         vld_relu   <= 1'b0;
         vld_wr     <= 1'b0;
         data_q     <= 16'h0000;
         neg_cnt    <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            len_q      <= LEN;
            mode_q     <= MODE;
            src_base_q <= SRC_BASE;
            dst_base_q <= DST_BASE;
            rd_idx     <= '0;
            wr_idx     <= '0;
            neg_cnt    <= '0;
         end
         if (state == S_RUN) rd_idx <= rd_idx + ADDR_W'(1);
         // ABORT flushes the pipeline so nothing issued earlier reaches the write port.
         vld_cap  <= (state == S_RUN) && !ABORT;
         vld_relu <= vld_cap && !ABORT;
         vld_wr   <= vld_relu && !ABORT;
         if (vld_cap) begin
            data_q <= SRC_DATA;
            if (SRC_DATA[15]) neg_cnt <= neg_cnt + ADDR_W'(1);
         end
         if (vld_wr) wr_idx <= wr_idx + ADDR_W'(1);
      end
   end

   assign SRC_RD_EN   = (state == S_RUN);
   assign SRC_ADDR    = src_base_q + rd_idx;
   assign Data_Reg    = data_q;
   assign BUSY        = (state != S_IDLE);
   assign EN_ReLU     = BUSY && mode_q[0];
   assign BYPASS_ReLU = BUSY && (mode_q == 2'b10);
   assign DST_WR_EN   = vld_wr;
   assign DST_ADDR    = dst_base_q + wr_idx;
   assign DST_DATA    = ReLU_OUT;
   assign DONE        = (state == S_FINISH) && !ABORT;
   assign NEG_CNT     = neg_cnt;

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// tb/tb_relu_seq_ctrl.sv - scoreboard bench for relu_seq_ctrl
// Stimulus queues expected reads/writes; a negedge monitor pops and compares them.
module tb_relu_seq_ctrl;

   logic        CLKEXT = 1'b0;
   logic        RST_GLO = 1'b1;
   logic        START = 1'b0;
   logic        ABORT = 1'b0;
   logic [7:0]  LEN = 8'h00;
   logic [1:0]  MODE = 2'b00;
   logic [7:0]  SRC_BASE = 8'h00;
   logic [7:0]  DST_BASE = 8'h00;
   logic        SRC_RD_EN;
   logic [7:0]  SRC_ADDR;
   logic [15:0] SRC_DATA = 16'h0000;
   logic [15:0] Data_Reg;
   logic        EN_ReLU;
   logic        BYPASS_ReLU;
   logic [15:0] ReLU_OUT = 16'h0000;
   logic        DST_WR_EN;
   logic [7:0]  DST_ADDR;
   logic [15:0] DST_DATA;
   logic        BUSY;
   logic        DONE;
   logic [7:0]  NEG_CNT;

   relu_seq_ctrl #(.ADDR_W(8)) dut (
      .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .START(START), .ABORT(ABORT),
      .LEN(LEN), .MODE(MODE), .SRC_BASE(SRC_BASE), .DST_BASE(DST_BASE),
      .SRC_RD_EN(SRC_RD_EN), .SRC_ADDR(SRC_ADDR), .SRC_DATA(SRC_DATA),
      .Data_Reg(Data_Reg), .EN_ReLU(EN_ReLU), .BYPASS_ReLU(BYPASS_ReLU),
      .ReLU_OUT(ReLU_OUT), .DST_WR_EN(DST_WR_EN), .DST_ADDR(DST_ADDR),
      .DST_DATA(DST_DATA), .BUSY(BUSY), .DONE(DONE), .NEG_CNT(NEG_CNT)
   );

   always #5 CLKEXT = ~CLKEXT;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rd_cnt, wr_cnt, done_cnt, first_wr, last_wr, done_cyc;
   logic [15:0] src_mem [256];
   logic [15:0] ed [8];
   logic [7:0]  exp_rd [$];
   logic [23:0] exp_wr [$];

   always @(posedge CLKEXT) cyc <= cyc + 1;

   always @(posedge CLKEXT) if (SRC_RD_EN) SRC_DATA <= src_mem[SRC_ADDR];

   // Behavioural stand-in for relu_module: registered, bypass > relu > zero.
   always @(posedge CLKEXT) begin
      if (RST_GLO)          ReLU_OUT <= 16'h0000;
      else if (BYPASS_ReLU) ReLU_OUT <= Data_Reg;
      else if (EN_ReLU)     ReLU_OUT <= Data_Reg[15] ? 16'h0000 : Data_Reg;
      else                  ReLU_OUT <= 16'h0000;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge CLKEXT) begin
      if (SRC_RD_EN === 1'b1) begin
         rd_cnt++;
         if (exp_rd.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read: addr %0h, expected no read", SRC_ADDR);
         end else begin
            chk("rd_addr", {24'h0, SRC_ADDR}, {24'h0, exp_rd.pop_front()});
         end
      end
      if (DST_WR_EN === 1'b1) begin
         if (wr_cnt == 0) first_wr = cyc;
         last_wr = cyc;
         wr_cnt++;
         if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr %0h data %0h, expected no write", DST_ADDR, DST_DATA);
         end else begin
            chk("wr_addr_data", {8'h0, DST_ADDR, DST_DATA}, {8'h0, exp_wr.pop_front()});
         end
      end
      if (DONE === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge CLKEXT);
      #2;
   endtask

   task automatic clear_mon();
      rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
      first_wr = -1; last_wr = -1; done_cyc = -1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_src_rd_en"}, {31'h0, SRC_RD_EN}, 0);
      chk({tag, "_dst_wr_en"}, {31'h0, DST_WR_EN}, 0);
      chk({tag, "_done"}, {31'h0, DONE}, 0);
      chk({tag, "_busy"}, {31'h0, BUSY}, 0);
      chk({tag, "_en_relu"}, {31'h0, EN_ReLU}, 0);
      chk({tag, "_bypass"}, {31'h0, BYPASS_ReLU}, 0);
      chk({tag, "_src_addr"}, {24'h0, SRC_ADDR}, 0);
      chk({tag, "_dst_addr"}, {24'h0, DST_ADDR}, 0);
      chk({tag, "_data_reg"}, {16'h0, Data_Reg}, 0);
      chk({tag, "_neg_cnt"}, {24'h0, NEG_CNT}, 0);
   endtask

   task automatic run_job(input string name, input logic [1:0] mode, input logic [7:0] len,
                          input logic [7:0] sb, input logic [7:0] db, input logic [7:0] neg,
                          input logic en, input logic byp, input int done_off, input int busy_k);
      int c0;
      clear_mon();
      for (int k = 0; k < int'(len); k++) begin
         exp_rd.push_back(8'(int'(sb) + k));
         exp_wr.push_back({8'(int'(db) + k), ed[k]});
      end
      MODE = mode; LEN = len; SRC_BASE = sb; DST_BASE = db; START = 1'b1;
      tick();
      START = 1'b0;
      c0 = cyc;
      chk({name, "_busy"}, {31'h0, BUSY}, 1);
      chk({name, "_en_relu"}, {31'h0, EN_ReLU}, {31'h0, en});
      chk({name, "_bypass"}, {31'h0, BYPASS_ReLU}, {31'h0, byp});
      for (int k = 0; k < 40; k++) begin
         if (done_cnt != 0) break;
         if (k == busy_k) begin
            START = 1'b1; LEN = 8'd5; MODE = 2'b00; SRC_BASE = 8'h80; DST_BASE = 8'h90;
         end
         tick();
         START = 1'b0;
      end
      tick();
      chk({name, "_done_cnt"}, done_cnt, 1);
      chk({name, "_done_cycle"}, done_cyc - c0, done_off);
      chk({name, "_wr_cnt"}, wr_cnt, {24'h0, len});
      chk({name, "_rd_cnt"}, rd_cnt, {24'h0, len});
      chk({name, "_neg_cnt"}, {24'h0, NEG_CNT}, {24'h0, neg});
      chk({name, "_busy_end"}, {31'h0, BUSY}, 0);
      chk({name, "_en_relu_idle"}, {31'h0, EN_ReLU}, 0);
      chk({name, "_sb_empty"}, exp_rd.size() + exp_wr.size(), 0);
      if (len != 8'd0) begin
         chk({name, "_first_wr"}, first_wr - c0, 3);
         chk({name, "_wr_span"}, last_wr - first_wr, int'(len) - 1);
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) src_mem[a] = 16'h0000;
      src_mem[8'h10] = 16'h0005; src_mem[8'h11] = 16'h8001;
      src_mem[8'h12] = 16'h7FFF; src_mem[8'h13] = 16'hFFFF;
      src_mem[8'hFE] = 16'h1234; src_mem[8'hFF] = 16'h9000; src_mem[8'h00] = 16'h0042;
      src_mem[8'h40] = 16'h0001; src_mem[8'h41] = 16'h0002; src_mem[8'h42] = 16'h0003;
      src_mem[8'h43] = 16'h8000; src_mem[8'h44] = 16'h8001; src_mem[8'h45] = 16'h8002;
      src_mem[8'h46] = 16'h8003; src_mem[8'h47] = 16'h8004;
      clear_mon();
      repeat (3) tick();
      chk_reset_vals("reset");
      RST_GLO = 1'b0;
      tick();

      ed = '{16'h0005, 16'h0000, 16'h7FFF, 16'h0000, 0, 0, 0, 0};
      run_job("relu", 2'b01, 8'd4, 8'h10, 8'h20, 8'd2, 1'b1, 1'b0, 7, 1);
      ed = '{16'h0005, 16'h8001, 16'h7FFF, 16'hFFFF, 0, 0, 0, 0};
      run_job("bypass", 2'b10, 8'd4, 8'h10, 8'h30, 8'd2, 1'b0, 1'b1, 7, -1);
      ed = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0};
      run_job("clear", 2'b00, 8'd4, 8'h10, 8'h20, 8'd2, 1'b0, 1'b0, 7, -1);
      ed = '{16'h0005, 16'h0000, 16'h7FFF, 16'h0000, 0, 0, 0, 0};
      run_job("relu11", 2'b11, 8'd4, 8'h10, 8'h50, 8'd2, 1'b1, 1'b0, 7, -1);
      ed = '{16'h1234, 16'h0000, 16'h0042, 0, 0, 0, 0, 0};
      run_job("wrap", 2'b01, 8'd3, 8'hFE, 8'hFF, 8'd1, 1'b1, 1'b0, 6, -1);
      run_job("len0", 2'b01, 8'd0, 8'h10, 8'h20, 8'd1, 1'b1, 1'b0, 0, -1);

      // ABORT during the third RUN cycle of an 8-element job.
      clear_mon();
      exp_rd.push_back(8'h40); exp_rd.push_back(8'h41); exp_rd.push_back(8'h42);
      MODE = 2'b01; LEN = 8'd8; SRC_BASE = 8'h40; DST_BASE = 8'h60; START = 1'b1;
      tick();
      START = 1'b0;
      tick();
      tick();
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      chk("abort_idle", {31'h0, BUSY}, 0);
      repeat (8) tick();
      chk("abort_wr_cnt", wr_cnt, 0);
      chk("abort_done_cnt", done_cnt, 0);
      chk("abort_rd_cnt", rd_cnt, 3);
      chk("abort_neg_cnt", {24'h0, NEG_CNT}, 0);
      chk("abort_sb_empty", exp_rd.size() + exp_wr.size(), 0);

      clear_mon();
      ABORT = 1'b1; START = 1'b1; LEN = 8'd4; SRC_BASE = 8'h10;
      tick();
      ABORT = 1'b0; START = 1'b0;
      chk("abort_start_busy", {31'h0, BUSY}, 0);
      repeat (5) tick();
      chk("abort_start_rd_cnt", rd_cnt, 0);
      chk("abort_start_done", done_cnt, 0);

      // Reset while draining; elements 0..2 are written before the reset edge.
      clear_mon();
      for (int k = 0; k < 4; k++) exp_rd.push_back(8'(8'h10 + k));
      exp_wr.push_back({8'h20, 16'h0005});
      exp_wr.push_back({8'h21, 16'h0000});
      exp_wr.push_back({8'h22, 16'h7FFF});
      MODE = 2'b01; LEN = 8'd4; SRC_BASE = 8'h10; DST_BASE = 8'h20; START = 1'b1;
      tick();
      START = 1'b0;
      repeat (5) tick();
      chk("rst_drain_busy", {31'h0, BUSY}, 1);
      RST_GLO = 1'b1;
      tick();
      chk_reset_vals("midrst");
      RST_GLO = 1'b0;
      chk("midrst_wr_cnt", wr_cnt, 3);
      chk("midrst_done", done_cnt, 0);
      chk("midrst_sb_empty", exp_rd.size() + exp_wr.size(), 0);
      repeat (3) tick();
      ed = '{16'h0005, 16'h8001, 16'h7FFF, 16'hFFFF, 0, 0, 0, 0};
      run_job("post_rst", 2'b10, 8'd4, 8'h10, 8'h70, 8'd2, 1'b0, 1'b1, 7, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
